cg_phase_sequencer: RTL

//  Sequences the solver's two shared compute units (matrix-vector mXv, vector-vector vXv) in place of bench-driven reset toggling.

---
 rtl/cg_ctrl_pkg.sv | 25 ++
 rtl/cg_cycle_counter.sv | 29 ++
 rtl/cg_phase_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cg_ctrl_pkg.sv
// Shared phase encoding for the CG solver sequencer, so status and debug logic
// decode phase identically.
package cg_ctrl_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE   = 3'd0,
        PH_PRE    = 3'd1,
        PH_MXV    = 3'd2,
        PH_GAP_MV = 3'd3,
        PH_VXV    = 3'd4,
        PH_GAP_VM = 3'd5,
        PH_HALT   = 3'd6
    } phase_e;

    function automatic logic is_gap(input phase_e p);
        return p inside {PH_PRE, PH_GAP_MV, PH_GAP_VM};
    endfunction

    function automatic logic is_unit(input phase_e p);
        return p inside {PH_MXV, PH_VXV};
    endfunction

endpackage

// File: rtl/cg_cycle_counter.sv
// Cycle counter with synchronous clear, count enable and a terminal-value flag.
module cg_cycle_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned TERM = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic at_term
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (cnt == TERM_V);

endmodule

// File: rtl/cg_phase_sequencer.sv
// Sequences the mXv and vXv units through alternating reset-released phases
// with settle gaps, iteration counting, convergence halt and a per-phase watchdog.
module cg_phase_sequencer
    import cg_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ITER = 16,
    parameter int unsigned ITER_W   = 5,
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned WD_CYC   = 1024,
    parameter int unsigned WD_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mxv_done,
    input  logic               vxv_done,
    input  logic               converged,
    output logic               mxv_rst,
    output logic               vxv_rst,
    output logic [PHASE_W-1:0] phase,
    output logic [ITER_W-1:0]  iter_cnt,
    output logic               busy,
    output logic               halt,
    output logic               wd_err
);

    localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
    localparam int unsigned WD_TERM = (WD_CYC == 0) ? 0 : WD_CYC - 1;

    phase_e            state, state_nx;
    logic [ITER_W-1:0] iter_nx;
    logic              wd_err_nx;
    logic              mxv_rst_nx, vxv_rst_nx, busy_nx, halt_nx;
    logic              gap_hit, wd_hit, wd_expire, last_iter, phase_change;

    // Both counters restart on every state change, which covers entry to each gap and unit phase.
    assign phase_change = (state_nx != state);

    cg_cycle_counter #(.W(GAP_W), .TERM(GAP_CYC - 1)) u_gap_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (phase_change),
        .en      (is_gap(state)),
        .at_term (gap_hit)
    );

    cg_cycle_counter #(.W(WD_W), .TERM(WD_TERM)) u_wd_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (phase_change),
        .en      (is_unit(state)),
        .at_term (wd_hit)
    );

    assign wd_expire = (WD_CYC != 0) && is_unit(state) && wd_hit;
    assign last_iter = (iter_cnt == ITER_W'(MAX_ITER - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= PH_IDLE;
            iter_cnt <= '0;
            wd_err   <= 1'b0;
            mxv_rst  <= 1'b1;
            vxv_rst  <= 1'b1;
            busy     <= 1'b0;
            halt     <= 1'b0;
        end else begin
            state    <= state_nx;
            iter_cnt <= iter_nx;
            wd_err   <= wd_err_nx;
            mxv_rst  <= mxv_rst_nx;
            vxv_rst  <= vxv_rst_nx;
            busy     <= busy_nx;
            halt     <= halt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        iter_nx   = iter_cnt;
        wd_err_nx = wd_err;
        if (abort && state != PH_IDLE) begin
            state_nx = PH_IDLE;
        end else begin
            unique case (state)
                PH_IDLE, PH_HALT: begin
                    if (start) begin
                        state_nx  = PH_PRE;
                        iter_nx   = '0;
                        wd_err_nx = 1'b0;
                    end
                end
                PH_PRE:    if (gap_hit) state_nx = PH_MXV;
                PH_GAP_MV: if (gap_hit) state_nx = PH_VXV;
                PH_GAP_VM: if (gap_hit) state_nx = PH_MXV;
                PH_MXV: begin
                    if (mxv_done) begin
                        state_nx = PH_GAP_MV;
                    end else if (wd_expire) begin
                        state_nx  = PH_HALT;
                        wd_err_nx = 1'b1;
                    end
                end
                PH_VXV: begin
                    if (vxv_done) begin
                        state_nx = (converged || last_iter) ? PH_HALT : PH_GAP_VM;
                        if (iter_cnt != ITER_W'(MAX_ITER)) iter_nx = iter_cnt + 1'b1;
                    end else if (wd_expire) begin
                        state_nx  = PH_HALT;
                        wd_err_nx = 1'b1;
                    end
                end
                default: state_nx = PH_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mxv_rst_nx = (state_nx != PH_MXV);
        vxv_rst_nx = (state_nx != PH_VXV);
        busy_nx    = (state_nx != PH_IDLE) && (state_nx != PH_HALT);
        halt_nx    = (state_nx == PH_HALT);
    end

    assign phase = state;

endmodule
